pipe_hazard_seq: RTL and testbench
==================================

PIPE_HAZARD_SEQ -- requirements
Module: pipe_hazard_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter WAIT_MAX, default 8, giving the consecutive dm_busy cycles allowed before timeout.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of each performance counter.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous reset, active high.
REQ-006 The block SHALL have port en, input, 1 bit: free-run enable.
REQ-007 The block SHALL have port step, input, 1 bit: single-step request level, used only while en=0.
REQ-008 The block SHALL have port ld_use, input, 1 bit: load-use hazard seen at ID.
REQ-009 The block SHALL have port mispredict, input, 1 bit: branch misprediction resolved at EX/DM.
REQ-010 The block SHALL have port halt_ps4, input, 1 bit: halting syscall present in writeback.
REQ-011 The block SHALL have port dm_busy, input, 1 bit: data memory requests a freeze.
REQ-012 The block SHALL have port en_ps, output, 5 bits: stage-register enables for PC and ps1..ps4.
REQ-013 The block SHALL have port clear_ps, output, 5 bits: stage-register clears; bit0 and bit4 are always 0.
REQ-014 The block SHALL have ports halted and mem_timeout, each output, 1 bit, each sticky status.
REQ-015 The block SHALL have ports cyc_cnt, bub_cnt, flush_cnt and stall_cnt, each output, CNT_W bits.

Function
REQ-016 States SHALL be RUN, MEM_WAIT and HALT; the encoding is internal.
REQ-017 en_ps and clear_ps SHALL be combinational from the current state and current inputs, with zero latency.
REQ-018 step_pulse SHALL equal step AND NOT step_q, where step_q is step registered; adv SHALL equal en OR step_pulse.
REQ-019 In RUN with dm_busy=0, en_ps[4:3] SHALL equal adv.
REQ-020 In RUN with dm_busy=0, en_ps[2:1] SHALL equal adv AND (mispredict OR NOT ld_use).
REQ-021 In RUN with dm_busy=0, en_ps[0] SHALL equal en_ps[1].
REQ-022 In RUN with dm_busy=0, clear_ps[1] and clear_ps[3] SHALL equal adv AND mispredict.
REQ-023 In RUN with dm_busy=0, clear_ps[2] SHALL equal adv AND (mispredict OR ld_use).
REQ-024 When mispredict and ld_use are both 1, mispredict SHALL win: stages advance and the bubble is absorbed by the clear.
REQ-025 In any state, dm_busy=1 SHALL force en_ps and clear_ps to 0 in the same cycle.
REQ-026 RUN SHALL go to MEM_WAIT when dm_busy=1.
REQ-027 MEM_WAIT SHALL go to RUN on the first cycle with dm_busy=0, and that cycle SHALL be evaluated as RUN.
REQ-028 wait_cnt SHALL count consecutive dm_busy cycles and clear when dm_busy=0.
REQ-029 When wait_cnt reaches WAIT_MAX, the block SHALL set mem_timeout and go to HALT.
REQ-030 In RUN, when adv, halt_ps4 and NOT dm_busy are all 1, the writeback cycle SHALL commit and the state SHALL be HALT next cycle.
REQ-031 HALT SHALL be absorbing until rst, with en_ps=0, clear_ps=0 and halted=1.
REQ-032 A held step level SHALL produce exactly one advance; step SHALL be ignored while en=1.
REQ-033 dm_busy rising in the same cycle as halt_ps4 SHALL freeze the pipeline; the halt SHALL be taken after dm_busy falls.

Reset
REQ-034 While rst=1, en_ps and clear_ps SHALL be 0.
REQ-035 On reset the state SHALL be RUN, and step_q, wait_cnt, halted, mem_timeout and all counters SHALL be 0.
REQ-036 Reset asserted mid-MEM_WAIT or in HALT SHALL return the block to RUN on the next edge.

Configuration
REQ-037 With macro PIPE_PERF_CNT_EN defined, the four counters SHALL saturate at all-ones.
REQ-038 cyc_cnt SHALL increment each non-HALT cycle.
REQ-039 bub_cnt SHALL increment when clear_ps[2] is set by ld_use alone.
REQ-040 flush_cnt SHALL increment when adv AND mispredict.
REQ-041 stall_cnt SHALL increment when dm_busy=1.
REQ-042 Without PIPE_PERF_CNT_EN, the counters SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-043 The shared package SHALL hold the state enum, the stage-index constants PS0..PS4 and the WAIT_MAX default.
REQ-044 One sub-module, sat_counter (CNT_W bits, inc input, saturating), SHALL be instantiated four times.

Verification
REQ-045 Scenario: en=1, ld_use=1 for one cycle -> en_ps=5'b11000, clear_ps=5'b00100, bub_cnt=1.
REQ-046 Scenario: en=1, mispredict=1, ld_use=1 -> en_ps=5'b11111, clear_ps=5'b01110, flush_cnt=1, bub_cnt=0.
REQ-047 Scenario: dm_busy=1 for 3 cycles -> en_ps=0 for exactly 3 cycles, stall_cnt=3, then RUN.
REQ-048 Scenario: dm_busy held for 8 cycles -> mem_timeout=1, halted=1, and en_ps stays 0 after dm_busy drops.
REQ-049 Scenario: en=0, step held high for 5 cycles -> en_ps=5'b11111 for exactly one cycle.
REQ-050 Scenario: halt_ps4=1 with en=1 -> en_ps=5'b11111 that cycle, halted=1 next cycle; a rst pulse then clears all outputs to 0.

Source files
------------

// File: rtl/pipe_hazard_seq_pkg.sv
// Shared types and constants for the pipeline hazard sequencer: FSM states,
// stage indices into the en_ps/clear_ps vectors, and the default timeout depth.
package pipe_hazard_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam int PS0 = 0;
  localparam int PS1 = 1;
  localparam int PS2 = 2;
  localparam int PS3 = 3;
  localparam int PS4 = 4;

  localparam int WAIT_MAX_DEF = 8;

endpackage

// File: rtl/pipe_hazard_seq_sat.sv
// sat_counter: CNT_W-bit up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_seq.sv
// Pipeline hazard sequencer: stage enables/clears for load-use, mispredict, memory freeze, halt.
// Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_seq
  import pipe_hazard_seq_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic             ld_use,
  input  logic             mispredict,
  input  logic             halt_ps4,
  input  logic             dm_busy,
  output logic [4:0]       en_ps,
  output logic [4:0]       clear_ps,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] bub_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              WC_W      = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);
  localparam logic [WC_W-1:0] WAIT_TOP  = WC_W'(WAIT_MAX);

  state_t          r_state;
  state_t          w_next_state;
  logic            r_step_q;
  logic [WC_W-1:0] r_wait_cnt;
  logic            r_halted;
  logic            r_mem_timeout;
  logic            w_step_pulse;
  logic            w_adv;
  logic            w_live;
  logic            w_timeout;
  logic [4:0]      w_en_ps;
  logic [4:0]      w_clear_ps;

  // MEM_WAIT with dm_busy low is evaluated exactly like RUN, so w_live ignores that distinction.
  always_comb begin
    w_step_pulse = step & ~r_step_q;
    w_adv        = en | w_step_pulse;
    w_live       = ~rst & ~dm_busy & (r_state != ST_HALT);
    w_en_ps      = '0;
    w_clear_ps   = '0;
    w_next_state = r_state;
    w_timeout    = 1'b0;

    if (w_live) begin
      w_en_ps[PS4]    = w_adv;
      w_en_ps[PS3]    = w_adv;
      w_en_ps[PS2]    = w_adv & (mispredict | ~ld_use);
      w_en_ps[PS1]    = w_adv & (mispredict | ~ld_use);
      w_en_ps[PS0]    = w_en_ps[PS1];
      w_clear_ps[PS1] = w_adv & mispredict;
      w_clear_ps[PS2] = w_adv & (mispredict | ld_use);
      w_clear_ps[PS3] = w_adv & mispredict;
    end

    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (dm_busy) begin
          if (r_wait_cnt == WAIT_LAST) begin
            w_next_state = ST_HALT;
            w_timeout    = 1'b1;
          end else begin
            w_next_state = ST_MEM_WAIT;
          end
        end else if (w_adv && halt_ps4) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      default: w_next_state = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_step_q      <= 1'b0;
      r_wait_cnt    <= '0;
      r_halted      <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_step_q <= step;
      if (!dm_busy) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_TOP) begin
        r_wait_cnt <= r_wait_cnt + WC_W'(1);
      end
      if (w_next_state == ST_HALT) begin
        r_halted <= 1'b1;
      end
      if (w_timeout) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign en_ps       = w_en_ps;
  assign clear_ps    = w_clear_ps;
  assign halted      = r_halted;
  assign mem_timeout = r_mem_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic w_inc_cyc;
  logic w_inc_bub;
  logic w_inc_flush;
  logic w_inc_stall;

  // A bubble is a PS2 clear caused by ld_use alone; mispredict-driven clears count as flushes.
  assign w_inc_cyc   = (r_state != ST_HALT);
  assign w_inc_bub   = w_clear_ps[PS2] & ld_use & ~mispredict;
  assign w_inc_flush = w_clear_ps[PS1];
  assign w_inc_stall = dm_busy;

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_cyc), .cnt(cyc_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_bub_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_bub), .cnt(bub_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_flush), .cnt(flush_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_stall), .cnt(stall_cnt)
  );
`else
  assign cyc_cnt   = '0;
  assign bub_cnt   = '0;
  assign flush_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_seq.sv
// Self-checking bench for pipe_hazard_seq: directed scenarios plus randomized traffic
// against a behavioural model; counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_hazard_seq;

  localparam int WMAX = 8;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst, en, step, ld_use, mispredict, halt_ps4, dm_busy;
  logic [4:0]    en_ps, clear_ps;
  logic          halted, mem_timeout;
  logic [CW-1:0] cyc_cnt, bub_cnt, flush_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit m_halt, m_to, m_stepq;
  int m_wait, m_cyc, m_bub, m_flush, m_stall;
  logic [4:0] exp_en, exp_clr, act_en, act_clr;

  pipe_hazard_seq #(.WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .step(step), .ld_use(ld_use),
    .mispredict(mispredict), .halt_ps4(halt_ps4), .dm_busy(dm_busy),
    .en_ps(en_ps), .clear_ps(clear_ps), .halted(halted), .mem_timeout(mem_timeout),
    .cyc_cnt(cyc_cnt), .bub_cnt(bub_cnt), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ecnt(input int raw);
`ifdef PIPE_PERF_CNT_EN
    return (raw > CMAX) ? CW'(CMAX) : CW'(raw);
`else
    return CW'(raw * 0);
`endif
  endfunction

  // Drives one cycle from a negedge, records the combinational outputs and the
  // model's prediction, then returns at the following negedge.
  task automatic drive(input bit r, input bit e, input bit s, input bit l,
                       input bit m, input bit h, input bit b);
    bit pulse, adv, frozen;
    rst = r; en = e; step = s; ld_use = l; mispredict = m; halt_ps4 = h; dm_busy = b;
    #1;
    pulse  = s && !m_stepq;
    adv    = e || pulse;
    frozen = r || b || m_halt;
    exp_en  = 5'b00000;
    exp_clr = 5'b00000;
    if (!frozen && adv) begin
      exp_en  = (l && !m) ? 5'b11000 : 5'b11111;
      exp_clr = m ? 5'b01110 : (l ? 5'b00100 : 5'b00000);
    end
    act_en  = en_ps;
    act_clr = clear_ps;
    if (r) begin
      m_halt = 0; m_to = 0; m_stepq = 0; m_wait = 0;
      m_cyc = 0; m_bub = 0; m_flush = 0; m_stall = 0;
    end else begin
      if (!m_halt) m_cyc++;
      if (b) m_stall++;
      if (!frozen && adv && m) m_flush++;
      if (!frozen && adv && l && !m) m_bub++;
      m_stepq = s;
      m_wait = b ? ((m_wait < WMAX) ? m_wait + 1 : m_wait) : 0;
      if (!m_halt) begin
        if (b && m_wait >= WMAX) begin
          m_to = 1; m_halt = 1;
        end else if (!b && adv && h) begin
          m_halt = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 1, 0);
    total++; if (act_en !== 5'b00000) begin bad++; $display("FAIL reset_en_ps got=%b want=00000", act_en); end
    total++; if (act_clr !== 5'b00000) begin bad++; $display("FAIL reset_clear_ps got=%b want=00000", act_clr); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", mem_timeout); end
    total++; if ({cyc_cnt, bub_cnt, flush_cnt, stall_cnt} !== '0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d/%0d/%0d want=0", cyc_cnt, bub_cnt, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_ld_use();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    total++; if (act_en !== 5'b11000) begin bad++; $display("FAIL lduse_en_ps got=%b want=11000", act_en); end
    total++; if (act_clr !== 5'b00100) begin bad++; $display("FAIL lduse_clear_ps got=%b want=00100", act_clr); end
    total++; if (bub_cnt !== ecnt(1)) begin bad++; $display("FAIL lduse_bub_cnt got=%0d want=%0d", bub_cnt, ecnt(1)); end
    drive(0, 1, 0, 0, 0, 0, 0);
    total++; if (act_en !== 5'b11111) begin bad++; $display("FAIL lduse_release got=%b want=11111", act_en); end
  endtask

  task automatic test_mispredict_wins();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 1, 0, 0);
    total++; if (act_en !== 5'b11111) begin bad++; $display("FAIL mp_en_ps got=%b want=11111", act_en); end
    total++; if (act_clr !== 5'b01110) begin bad++; $display("FAIL mp_clear_ps got=%b want=01110", act_clr); end
    total++; if (flush_cnt !== ecnt(1)) begin bad++; $display("FAIL mp_flush_cnt got=%0d want=%0d", flush_cnt, ecnt(1)); end
    total++; if (bub_cnt !== ecnt(0)) begin bad++; $display("FAIL mp_bub_cnt got=%0d want=%0d", bub_cnt, ecnt(0)); end
  endtask

  task automatic test_mem_stall();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 1, 1, 1);
      total++; if ({act_en, act_clr} !== 10'b0) begin bad++; $display("FAIL stall_frozen cyc=%0d got=%b/%b want=0", i, act_en, act_clr); end
    end
    total++; if (stall_cnt !== ecnt(3)) begin bad++; $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, ecnt(3)); end
    drive(0, 1, 0, 0, 0, 0, 0);
    total++; if (act_en !== 5'b11111) begin bad++; $display("FAIL stall_resume got=%b want=11111", act_en); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL stall_not_halted got=%b want=0", halted); end
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < WMAX - 1; i++) drive(0, 1, 0, 0, 0, 0, 1);
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", mem_timeout); end
    drive(0, 1, 0, 0, 0, 0, 1);
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b want=1", mem_timeout); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL timeout_halted got=%b want=1", halted); end
    drive(0, 1, 0, 0, 0, 0, 0);
    total++; if (act_en !== 5'b00000) begin bad++; $display("FAIL timeout_en_after got=%b want=00000", act_en); end
  endtask

  task automatic test_step();
    int ones = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      if (act_en === 5'b11111) ones++;
      total++; if (act_en !== exp_en) begin bad++; $display("FAIL step_en cyc=%0d got=%b want=%b", i, act_en, exp_en); end
    end
    total++; if (ones !== 1) begin bad++; $display("FAIL step_once got=%0d want=1", ones); end
    drive(0, 1, 1, 0, 0, 0, 0);
    total++; if (act_en !== 5'b11111) begin bad++; $display("FAIL step_en_mode got=%b want=11111", act_en); end
  endtask

  task automatic test_halt();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0);
    total++; if (act_en !== 5'b11111) begin bad++; $display("FAIL halt_commit got=%b want=11111", act_en); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b want=1", halted); end
    drive(0, 1, 0, 0, 1, 0, 0);
    total++; if ({act_en, act_clr} !== 10'b0) begin bad++; $display("FAIL halt_absorb got=%b/%b want=0", act_en, act_clr); end
    drive(1, 1, 0, 0, 0, 0, 0);
    total++; if ({halted, mem_timeout, cyc_cnt, bub_cnt, flush_cnt, stall_cnt} !== '0) begin
      bad++; $display("FAIL halt_rst_clear got=%b %b %0d %0d %0d %0d want=0", halted, mem_timeout, cyc_cnt, bub_cnt, flush_cnt, stall_cnt);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    total++; if (act_en !== 5'b11111) begin bad++; $display("FAIL halt_rst_run got=%b want=11111", act_en); end
  endtask

  task automatic test_halt_busy();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 1);
    total++; if (act_en !== 5'b00000) begin bad++; $display("FAIL hb_frozen got=%b want=00000", act_en); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL hb_no_halt got=%b want=0", halted); end
    drive(0, 1, 0, 0, 0, 1, 0);
    total++; if (act_en !== 5'b11111) begin bad++; $display("FAIL hb_commit got=%b want=11111", act_en); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL hb_halt got=%b want=1", halted); end
  endtask

  task automatic test_reset_mid_wait();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 1);
    total++; if (act_en !== 5'b00000) begin bad++; $display("FAIL rmw_en_in_rst got=%b want=00000", act_en); end
    drive(0, 1, 0, 0, 0, 0, 0);
    total++; if (act_en !== 5'b11111) begin bad++; $display("FAIL rmw_run got=%b want=11111", act_en); end
  endtask

  task automatic test_random();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) < 3), ($urandom_range(99) < 60), $urandom_range(1),
            ($urandom_range(99) < 30), ($urandom_range(99) < 20),
            ($urandom_range(99) < 4), ($urandom_range(99) < 30));
      total++; if ({act_en, act_clr} !== {exp_en, exp_clr}) begin
        bad++; $display("FAIL rnd_comb cyc=%0d got=%b/%b want=%b/%b", i, act_en, act_clr, exp_en, exp_clr);
      end
      total++; if ({halted, mem_timeout} !== {m_halt, m_to}) begin
        bad++; $display("FAIL rnd_status cyc=%0d got=%b%b want=%b%b", i, halted, mem_timeout, m_halt, m_to);
      end
      total++; if ({cyc_cnt, bub_cnt, flush_cnt, stall_cnt} !== {ecnt(m_cyc), ecnt(m_bub), ecnt(m_flush), ecnt(m_stall)}) begin
        bad++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", i,
                        cyc_cnt, bub_cnt, flush_cnt, stall_cnt, ecnt(m_cyc), ecnt(m_bub), ecnt(m_flush), ecnt(m_stall));
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; step = 1'b0; ld_use = 1'b0;
    mispredict = 1'b0; halt_ps4 = 1'b0; dm_busy = 1'b0;
    @(negedge clk);
    test_reset();
    test_ld_use();
    test_mispredict_wins();
    test_mem_stall();
    test_timeout();
    test_step();
    test_halt();
    test_halt_busy();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
